i2s_tx_ctrl: RTL
================

# i2s_tx_ctrl

Transmit-side controller for the I2S transceiver. It pops stereo sample pairs (left word, then right word) from the transmit FIFO and acts as I2S master. It generates SCK and WS, and serialises the samples MSB-first with the standard one-SCK WS-to-MSB delay. It sits between the FIFO read port and the I2S pins, and is the only agent driving the FIFO's RD strobe.

## Interface
- CLK_DIV, 4, system clocks per SCK half-period; legal range 2..255
- WORD_W, 32, sample width per channel; fixed at 32 in this revision
- clk  input  1  system clock; also drives the FIFO read clock
- Rst  input  1  asynchronous, active-high reset
- EN  input  1  run enable; also gates FIFO prefetch
- fifo_empty  input  1  FIFO EMPTY flag
- fifo_data  input  32  FIFO dataOut; valid on the clk after a fifo_rd cycle
- fifo_rd  output  1  FIFO read strobe, one clk per word
- sck  output  1  I2S bit clock, registered
- ws  output  1  word select, registered; 0 = left, 1 = right
- sd  output  1  serial data, registered; changes only with sck falling
- underrun  output  1  one-clk pulse when a frame starts with no pair available
- busy  output  1  high while in RUN or FLUSH

## Operation
- **Reset values:** all outputs 0. Both FSMs are in their idle states, pair_valid = 0, counters = 0, and the holding and shift registers = 0.
- **Fill FSM:** F_IDLE -> F_RD_L -> F_CAP_L -> F_RD_R -> F_CAP_R -> F_IDLE.
  - Leave F_IDLE when EN=1 and pair_valid=0.
  - In F_RD_x, drive fifo_rd=1 only when fifo_empty=0, then advance. If the FIFO is empty, wait there with fifo_rd=0.
  - F_CAP_x samples fifo_data into hold_l or hold_r. Leaving F_CAP_R sets pair_valid=1.
  - A read already issued always completes its capture, even if EN falls.
  - A half-fetched pair is never consumed.
- **Bit divider:** div_cnt counts 0..CLK_DIV-1. At terminal count, sck toggles and div_cnt returns to 0. An sck 1->0 toggle is a "fall event".
- **Tx FSM states:** IDLE, RUN, FLUSH.
  - IDLE -> RUN when EN=1 and pair_valid=1. In that same clk: sr = {hold_l, hold_r}, slot = 0, ws = 0, sd = 0, sck = 0, div_cnt = 0, pair_valid cleared.
- **RUN, each fall event:**
  - slot increments mod 64.
  - sd <= sr[63], then sr shifts left by one.
  - ws <= 1 for new slot 32..63, 0 for slot 0..31.
- **Frame boundary** is a fall event entering slot 0. sd still takes the old sr[63], which is the previous right LSB. Then:
  - EN=1 and pair_valid=1: load sr = {hold_l, hold_r}; clear pair_valid.
  - EN=1 and pair_valid=0: load sr = 0 and pulse underrun for that clk; the frame transmits zeros.
  - EN=0: go to FLUSH; nothing loaded; pair_valid and hold registers are retained.
- **FLUSH:** slot 0 runs normally (ws = 0, sd = right LSB). At the next fall event, go to IDLE with sd = 0 and ws = 0. sck stays 0 in IDLE.
- **Resulting slot map:** slot 1..32 carries L[31..0]; slot 33..63 carries R[31..1]; the next frame's slot 0 carries R[0].
- **Reset mid-operation:** immediate return to reset values. Any partial frame and pair_valid are discarded; the FIFO is not re-read.

## Timing
- SCK period is 2*CLK_DIV clks. A frame is 64 SCK periods = 128*CLK_DIV clks.
- sck, ws and sd change in the same clk. In RUN, ws and sd change only on sck falling.
- fifo_rd is asserted in cycle n; fifo_data is sampled at the end of cycle n+1.
- A full refill takes a minimum of 4 clks with the FIFO non-empty, well inside one frame for CLK_DIV >= 2.
- Start latency: pair_valid set to RUN entry in 1 clk. First sck rise after CLK_DIV clks; first fall (L MSB on sd) after 2*CLK_DIV clks.
- Simultaneous boundary and F_CAP_R completion: the boundary sees the old pair_valid. That pair is used at the next boundary.
- busy goes low in the clk after the FLUSH exit event.

## Test plan
- **Reset:** assert Rst mid-simulation with no clk edges. All outputs read 0 immediately; fifo_rd stays 0 while EN=0.
- **Basic frame:** CLK_DIV=2; FIFO preloaded with L=0xA5A50001, R=0x80000003; EN=1. Required:
  - exactly two fifo_rd pulses;
  - sck period 4 clks;
  - slot 1 sd=1, slot 32 sd=1 (L LSB), ws rises entering slot 32, slot 33 sd=1 (R MSB);
  - next frame's slot 0 carries sd=1 (R LSB) with ws=0.
- **Underrun:** only one pair in the FIFO. The second frame boundary gives a one-clk underrun pulse, slot 0 sd=1 (R LSB), then slots 1..63 sd=0. Pushing a new pair resumes data at the following boundary.
- **Half pair:** FIFO holds only L=0x12345678. Required:
  - one fifo_rd pulse, then the fill FSM waits in F_RD_R with no start and busy=0;
  - pushing R=0x0000FFFF gives the second fifo_rd, and the frame transmits L and R correctly.
- **Stop:** drop EN at slot 10 of a frame. Required:
  - the frame completes;
  - FLUSH emits slot 0 with R LSB;
  - then sck, ws, sd = 0 and busy=0;
  - no further fifo_rd while EN=0; the held pair is transmitted when EN returns.
- **Async reset mid-frame:** Rst at slot 40. Outputs are 0 within the same clk; after release with EN=1, the next pair is fetched fresh from the FIFO.

Source files
------------

// File: rtl/i2s_tx_ctrl_if.sv
// FIFO read port and I2S pin bundle of the transmit controller.
// master = controller side, slave = FIFO/pin side.
interface i2s_tx_ctrl_if #(
  parameter int WORD_W = 32
);
  logic              en;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_data;
  logic              fifo_rd;
  logic              sck;
  logic              ws;
  logic              sd;
  logic              underrun;
  logic              busy;

  modport master (
    input  en, fifo_empty, fifo_data,
    output fifo_rd, sck, ws, sd, underrun, busy
  );

  modport slave (
    output en, fifo_empty, fifo_data,
    input  fifo_rd, sck, ws, sd, underrun, busy
  );
endinterface

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit master: prefetches a stereo pair from the FIFO into holding
// registers and shifts it out MSB-first with the one-SCK WS-to-MSB delay.
module i2s_tx_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  i2s_tx_ctrl_if.master bus
);

  localparam int         SR_W     = 2 * WORD_W;
  localparam int         SLOT_W   = $clog2(SR_W);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  localparam logic [2:0] F_IDLE  = 3'd0;
  localparam logic [2:0] F_RD_L  = 3'd1;
  localparam logic [2:0] F_CAP_L = 3'd2;
  localparam logic [2:0] F_RD_R  = 3'd3;
  localparam logic [2:0] F_CAP_R = 3'd4;

  localparam logic [1:0] T_IDLE  = 2'd0;
  localparam logic [1:0] T_RUN   = 2'd1;
  localparam logic [1:0] T_FLUSH = 2'd2;

  logic [2:0]        fill_state_q, fill_state_d;
  logic [1:0]        tx_state_q, tx_state_d;
  logic              pair_valid_q, pair_valid_d;
  logic [WORD_W-1:0] hold_l_q, hold_l_d;
  logic [WORD_W-1:0] hold_r_q, hold_r_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [7:0]        div_cnt_q, div_cnt_d;
  logic              sck_q, sck_d;
  logic              ws_q, ws_d;
  logic              sd_q, sd_d;
  logic              underrun_q, underrun_d;

  logic              fifo_rd_c;
  logic              pair_set;
  logic              pair_take;
  logic              div_tc;
  logic              fall_evt;
  logic [SLOT_W-1:0] slot_inc;

  assign div_tc   = (div_cnt_q == DIV_LAST);
  assign fall_evt = div_tc & sck_q;
  assign slot_inc = slot_q + SLOT_W'(1);

  // Fill FSM: a read once issued always reaches its capture state, so a
  // dropped EN can only park the FSM in one of the F_RD_x states.
  always_comb begin
    fill_state_d = fill_state_q;
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    fifo_rd_c    = 1'b0;
    pair_set     = 1'b0;
    case (fill_state_q)
      F_IDLE: begin
        if (bus.en && !pair_valid_q) begin
          fill_state_d = F_RD_L;
        end
      end
      F_RD_L: begin
        if (bus.en && !bus.fifo_empty) begin
          fifo_rd_c    = 1'b1;
          fill_state_d = F_CAP_L;
        end
      end
      F_CAP_L: begin
        hold_l_d     = bus.fifo_data;
        fill_state_d = F_RD_R;
      end
      F_RD_R: begin
        if (bus.en && !bus.fifo_empty) begin
          fifo_rd_c    = 1'b1;
          fill_state_d = F_CAP_R;
        end
      end
      F_CAP_R: begin
        hold_r_d     = bus.fifo_data;
        pair_set     = 1'b1;
        fill_state_d = F_IDLE;
      end
      default: fill_state_d = F_IDLE;
    endcase
  end

  // Tx FSM, bit divider and shifter. Everything visible on the pins moves
  // together on a fall event so ws/sd never change while sck is high.
  always_comb begin
    tx_state_d = tx_state_q;
    sr_d       = sr_q;
    slot_d     = slot_q;
    div_cnt_d  = div_cnt_q;
    sck_d      = sck_q;
    ws_d       = ws_q;
    sd_d       = sd_q;
    underrun_d = 1'b0;
    pair_take  = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        sck_d     = 1'b0;
        ws_d      = 1'b0;
        sd_d      = 1'b0;
        slot_d    = '0;
        div_cnt_d = '0;
        if (bus.en && pair_valid_q) begin
          tx_state_d = T_RUN;
          sr_d       = {hold_l_q, hold_r_q};
          pair_take  = 1'b1;
        end
      end
      T_RUN, T_FLUSH: begin
        if (div_tc) begin
          div_cnt_d = '0;
          sck_d     = ~sck_q;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
        if (fall_evt) begin
          if (tx_state_q == T_RUN) begin
            slot_d = slot_inc;
            sd_d   = sr_q[SR_W-1];
            sr_d   = {sr_q[SR_W-2:0], 1'b0};
            ws_d   = slot_inc[SLOT_W-1];
            // Frame boundary: the previous right LSB is already on its way
            // out via sd_d; decide what the new frame carries.
            if (slot_inc == '0) begin
              if (!bus.en) begin
                tx_state_d = T_FLUSH;
              end else if (pair_valid_q) begin
                sr_d      = {hold_l_q, hold_r_q};
                pair_take = 1'b1;
              end else begin
                sr_d       = '0;
                underrun_d = 1'b1;
              end
            end
          end else begin
            tx_state_d = T_IDLE;
            sd_d       = 1'b0;
            ws_d       = 1'b0;
            slot_d     = '0;
            div_cnt_d  = '0;
          end
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // pair_set only fires after a fill that began with pair_valid low, so it
  // can never coincide with a consume of the same pair.
  always_comb begin
    pair_valid_d = pair_valid_q;
    if (pair_set) begin
      pair_valid_d = 1'b1;
    end else if (pair_take) begin
      pair_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_state_q <= F_IDLE;
      tx_state_q   <= T_IDLE;
      pair_valid_q <= 1'b0;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
      sr_q         <= '0;
      slot_q       <= '0;
      div_cnt_q    <= '0;
      sck_q        <= 1'b0;
      ws_q         <= 1'b0;
      sd_q         <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      fill_state_q <= fill_state_d;
      tx_state_q   <= tx_state_d;
      pair_valid_q <= pair_valid_d;
      hold_l_q     <= hold_l_d;
      hold_r_q     <= hold_r_d;
      sr_q         <= sr_d;
      slot_q       <= slot_d;
      div_cnt_q    <= div_cnt_d;
      sck_q        <= sck_d;
      ws_q         <= ws_d;
      sd_q         <= sd_d;
      underrun_q   <= underrun_d;
    end
  end

  assign bus.fifo_rd  = fifo_rd_c;
  assign bus.sck      = sck_q;
  assign bus.ws       = ws_q;
  assign bus.sd       = sd_q;
  assign bus.underrun = underrun_q;
  assign bus.busy     = (tx_state_q != T_IDLE);

endmodule
